// File: rtl/pipeline_redirect_control_pkg.sv
// rtl/pipeline_redirect_control_pkg.sv - shared core control encodings for the redirect controller
package pipeline_redirect_control_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_FLUSH = 2'd3
    } ctrl_state_t;

    typedef enum logic [1:0] {
        SEL_PC_PLUS4 = 2'b00,
        SEL_HOLD     = 2'b01,
        SEL_TARGET   = 2'b10,
        SEL_RESET    = 2'b11
    } pc_sel_t;

    localparam int FLUSH_COUNT_BITS = 3;

    // Saturating increment: the free-running cycle counter must stick at all-ones.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/redirect_flush_counter.sv
// rtl/redirect_flush_counter.sv - loadable down-counter timing the post-redirect flush window
module redirect_flush_counter
    import pipeline_redirect_control_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        load,
    input  logic [FLUSH_COUNT_BITS-1:0] load_value,
    input  logic                        decrement,
    output logic [FLUSH_COUNT_BITS-1:0] count,
    output logic                        zero
);

    // Load wins over decrement so a fresh redirect restarts the window; decrement stops at zero.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (decrement && count != '0) begin
            count <= count - FLUSH_COUNT_BITS'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pipeline_redirect_control.sv
// rtl/pipeline_redirect_control.sv - fetch redirect, stall and flush sequencing for the core pipeline
module pipeline_redirect_control
    import pipeline_redirect_control_pkg::*;
#(
    parameter int                      ADDRESS_BITS    = 20,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC        = '0,
    parameter int                      FLUSH_CYCLES    = 2,
    parameter int                      SCAN_CYCLES_MIN = 0,
    parameter int                      SCAN_CYCLES_MAX = 1000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    JALR_branch_hazard,
    input  logic [ADDRESS_BITS-1:0] exec_target,
    input  logic                    JAL_hazard,
    input  logic [ADDRESS_BITS-1:0] JAL_target_decode,
    input  logic                    true_data_hazard,
    input  logic                    d_mem_issue_hazard,
    input  logic                    d_mem_recv_hazard,
    input  logic                    i_mem_hazard,
    output logic [1:0]              next_PC_sel,
    output logic [ADDRESS_BITS-1:0] target_PC,
    output logic                    i_mem_read,
    output logic                    stall_fetch,
    output logic                    stall_decode,
    output logic                    flush_decode,
    output logic                    flush_execute,
    output logic [1:0]              state,
    output logic [31:0]             cycle_count,
    input  logic                    scan,
    output logic                    scan_active
);

    localparam logic [FLUSH_COUNT_BITS-1:0] FLUSH_RELOAD = FLUSH_COUNT_BITS'(FLUSH_CYCLES - 1);
    localparam bit                          LONG_FLUSH   = (FLUSH_CYCLES > 1);
    localparam logic [31:0]                 SCAN_LO      = 32'(SCAN_CYCLES_MIN);
    localparam logic [31:0]                 SCAN_SPAN    = 32'(SCAN_CYCLES_MAX - SCAN_CYCLES_MIN);

    ctrl_state_t             state_q, state_d;
    logic                    pend_q, pend_exec_q;
    logic [ADDRESS_BITS-1:0] pend_addr_q, target_q;
    logic [31:0]             cycle_q;

    logic                        stall_cause;
    logic                        issue, issue_exec;
    logic [ADDRESS_BITS-1:0]     issue_addr;
    logic                        latch_pend, latch_exec;
    logic [ADDRESS_BITS-1:0]     latch_addr;
    logic                        cnt_load, cnt_dec;
    logic [FLUSH_COUNT_BITS-1:0] flush_count;
    logic                        flush_zero;
    pc_sel_t                     sel;
    logic [ADDRESS_BITS-1:0]     tgt;
    logic                        rd, sf, sd, fd, fe;

    redirect_flush_counter u_flush_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (FLUSH_RELOAD),
        .decrement  (cnt_dec),
        .count      (flush_count),
        .zero       (flush_zero)
    );

    assign stall_cause = true_data_hazard | d_mem_issue_hazard | d_mem_recv_hazard | i_mem_hazard;

    // Decide this cycle's redirect/stall/flush controls and the next state from the inputs.
    always_comb begin
        issue      = 1'b0;
        issue_exec = 1'b0;
        issue_addr = target_q;
        latch_pend = 1'b0;
        latch_exec = 1'b0;
        latch_addr = exec_target;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        state_d    = state_q;
        sel        = SEL_PC_PLUS4;
        tgt        = target_q;
        rd         = 1'b0;
        sf         = 1'b0;
        sd         = 1'b0;
        fd         = 1'b0;
        fe         = 1'b0;
        case (state_q)
            ST_BOOT: begin
                sel     = SEL_RESET;
                rd      = !i_mem_hazard;
                state_d = ST_RUN;
            end
            ST_FLUSH: begin
                fd = 1'b1;
                fe = 1'b1;
                rd = flush_zero && !i_mem_hazard;
                // A younger execute redirect restarts the window; decode-stage JALs are wrong-path here.
                if (JALR_branch_hazard) begin
                    sel        = SEL_TARGET;
                    tgt        = exec_target;
                    issue      = 1'b1;
                    issue_exec = 1'b1;
                    issue_addr = exec_target;
                    cnt_load   = 1'b1;
                    state_d    = LONG_FLUSH ? ST_FLUSH : ST_RUN;
                end else begin
                    sel     = SEL_HOLD;
                    cnt_dec = 1'b1;
                    if (flush_count <= FLUSH_COUNT_BITS'(1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                // Fetch cannot take a new PC while instruction memory is busy, so park the redirect.
                if (!i_mem_hazard) begin
                    if (JALR_branch_hazard) begin
                        issue      = 1'b1;
                        issue_exec = 1'b1;
                        issue_addr = exec_target;
                    end else if (pend_q) begin
                        issue      = 1'b1;
                        issue_exec = pend_exec_q;
                        issue_addr = pend_addr_q;
                    end else if (JAL_hazard) begin
                        issue      = 1'b1;
                        issue_addr = JAL_target_decode;
                    end
                end else begin
                    if (JALR_branch_hazard) begin
                        latch_pend = 1'b1;
                        latch_exec = 1'b1;
                        latch_addr = exec_target;
                    end else if (JAL_hazard && !pend_q) begin
                        latch_pend = 1'b1;
                        latch_addr = JAL_target_decode;
                    end
                end
                if (issue) begin
                    sel = SEL_TARGET;
                    tgt = issue_addr;
                    rd  = 1'b1;
                    fd  = 1'b1;
                    fe  = issue_exec;
                    if (issue_exec && LONG_FLUSH) begin
                        cnt_load = 1'b1;
                        state_d  = ST_FLUSH;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (stall_cause) begin
                    sel     = SEL_HOLD;
                    sf      = 1'b1;
                    sd      = 1'b1;
                    fe      = true_data_hazard;
                    rd      = !i_mem_hazard;
                    state_d = ST_STALL;
                end else begin
                    rd      = 1'b1;
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    // FSM, pending redirect, last target and cycle counter registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_BOOT;
            pend_q      <= 1'b0;
            pend_exec_q <= 1'b0;
            pend_addr_q <= RESET_PC;
            target_q    <= RESET_PC;
            cycle_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            cycle_q <= sat_inc32(cycle_q);
            if (issue) begin
                target_q <= issue_addr;
                pend_q   <= 1'b0;
            end else if (latch_pend) begin
                pend_q      <= 1'b1;
                pend_exec_q <= latch_exec;
                pend_addr_q <= latch_addr;
            end
        end
    end

    // Reset holds the outputs at their boot values regardless of register contents.
    assign next_PC_sel   = reset ? sel : SEL_RESET;
    assign target_PC     = reset ? tgt : RESET_PC;
    assign i_mem_read    = reset && rd;
    assign stall_fetch   = reset && sf;
    assign stall_decode  = reset && sd;
    assign flush_decode  = reset && fd;
    assign flush_execute = reset && fe;
    assign state         = reset ? state_q : ST_BOOT;
    assign cycle_count   = reset ? cycle_q : 32'd0;
    // Unsigned wrap makes counts below the window fall outside the span.
    assign scan_active   = reset && scan && ((cycle_q - SCAN_LO) <= SCAN_SPAN);

endmodule

// File: tb/tb_pipeline_redirect_control.sv
// tb/tb_pipeline_redirect_control.sv - self-checking bench for pipeline_redirect_control
module tb_pipeline_redirect_control;

    localparam int          AB       = 20;
    localparam logic [19:0] RST_PC   = 20'h00040;
    localparam int          FC       = 2;
    localparam int          SMIN     = 3;
    localparam int          SMAX     = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic          jalr, jal, tdh, dmi, dmr, imh, scan;
    logic [AB-1:0] exec_target, jal_target;
    logic [1:0]    next_PC_sel;
    logic [AB-1:0] target_PC;
    logic          i_mem_read, stall_fetch, stall_decode, flush_decode, flush_execute;
    logic [1:0]    state;
    logic [31:0]   cycle_count;
    logic          scan_active;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pipeline_redirect_control #(
        .ADDRESS_BITS(AB), .RESET_PC(RST_PC), .FLUSH_CYCLES(FC),
        .SCAN_CYCLES_MIN(SMIN), .SCAN_CYCLES_MAX(SMAX)
    ) dut (
        .clock(clock), .reset(reset),
        .JALR_branch_hazard(jalr), .exec_target(exec_target),
        .JAL_hazard(jal), .JAL_target_decode(jal_target),
        .true_data_hazard(tdh), .d_mem_issue_hazard(dmi),
        .d_mem_recv_hazard(dmr), .i_mem_hazard(imh),
        .next_PC_sel(next_PC_sel), .target_PC(target_PC), .i_mem_read(i_mem_read),
        .stall_fetch(stall_fetch), .stall_decode(stall_decode),
        .flush_decode(flush_decode), .flush_execute(flush_execute),
        .state(state), .cycle_count(cycle_count),
        .scan(scan), .scan_active(scan_active)
    );

    // Reference model: "booting" flag, remaining flush cycles, a parked redirect, last target, elapsed cycles.
    bit          m_boot = 1'b1, m_pend = 1'b0, m_pend_exec = 1'b0, m_prev_stall = 1'b0;
    int          m_flush_left = 0;
    logic [19:0] m_pend_addr = '0, m_tgt = RST_PC;
    longint      m_cyc = 0;
    bit          n_pend, n_pend_exec, n_prev_stall;
    int          n_flush_left;
    logic [19:0] n_pend_addr, n_tgt;
    longint      n_cyc;
    logic [1:0]  e_sel, e_state;
    logic [19:0] e_tgt;
    logic        e_rd, e_sf, e_sd, e_fd, e_fe, e_scan;
    logic [31:0] e_cc;

    task automatic model_eval();
        bit          stall_any, do_issue, do_exec;
        logic [19:0] addr;
        stall_any = tdh | dmi | dmr | imh;
        do_issue = 1'b0; do_exec = 1'b0; addr = '0;
        n_flush_left = m_flush_left; n_pend = m_pend; n_pend_exec = m_pend_exec;
        n_pend_addr = m_pend_addr; n_tgt = m_tgt; n_prev_stall = 1'b0;
        n_cyc = (m_cyc == 64'hFFFF_FFFF) ? m_cyc : m_cyc + 1;
        e_sel = 2'b00; e_tgt = m_tgt; e_rd = 0; e_sf = 0; e_sd = 0; e_fd = 0; e_fe = 0;
        e_cc = m_cyc[31:0];
        e_scan = scan && (m_cyc >= SMIN) && (m_cyc <= SMAX);
        e_state = m_boot ? 2'd0 : (m_flush_left > 0) ? 2'd3 : m_prev_stall ? 2'd2 : 2'd1;
        if (!reset) begin
            e_sel = 2'b11; e_tgt = RST_PC; e_cc = 0; e_scan = 0; e_state = 2'd0;
        end else if (m_boot) begin
            e_sel = 2'b11; e_rd = !imh;
        end else if (m_flush_left > 0) begin
            e_fd = 1; e_fe = 1;
            if (jalr) begin
                e_sel = 2'b10; e_tgt = exec_target; n_tgt = exec_target; n_flush_left = FC - 1;
            end else begin
                e_sel = 2'b01; n_flush_left = m_flush_left - 1;
            end
        end else begin
            if (!imh) begin
                if (jalr) begin do_issue = 1; do_exec = 1; addr = exec_target; end
                else if (m_pend) begin do_issue = 1; do_exec = m_pend_exec; addr = m_pend_addr; end
                else if (jal) begin do_issue = 1; addr = jal_target; end
            end else if (jalr) begin
                n_pend = 1; n_pend_exec = 1; n_pend_addr = exec_target;
            end else if (jal && !m_pend) begin
                n_pend = 1; n_pend_exec = 0; n_pend_addr = jal_target;
            end
            if (do_issue) begin
                e_sel = 2'b10; e_tgt = addr; n_tgt = addr; e_rd = 1; e_fd = 1; e_fe = do_exec;
                n_pend = 0; n_flush_left = do_exec ? FC - 1 : 0;
            end else if (stall_any) begin
                e_sel = 2'b01; e_sf = 1; e_sd = 1; e_fe = tdh; e_rd = !imh; n_prev_stall = 1;
            end else begin
                e_rd = 1;
            end
        end
    endtask

    task automatic model_commit();
        if (!reset) begin
            m_boot = 1; m_flush_left = 0; m_pend = 0; m_pend_exec = 0;
            m_tgt = RST_PC; m_cyc = 0; m_prev_stall = 0;
        end else begin
            m_boot = 0; m_flush_left = n_flush_left; m_pend = n_pend; m_pend_exec = n_pend_exec;
            m_pend_addr = n_pend_addr; m_tgt = n_tgt; m_cyc = n_cyc; m_prev_stall = n_prev_stall;
        end
    endtask

    task automatic clear_inputs();
        jalr = 0; jal = 0; tdh = 0; dmi = 0; dmr = 0; imh = 0; scan = 0;
        exec_target = '0; jal_target = '0;
    endtask

    task automatic settle();
        model_eval();
        #2;
    endtask

    task automatic tick();
        model_eval();
        @(posedge clock);
        model_commit();
        #1;
    endtask

    task automatic test_reset();
        clear_inputs(); reset = 0; scan = 1;
        for (int i = 0; i < 5; i++) begin
            settle();
            checks++; if (next_PC_sel !== 2'b11) begin errors++; $display("FAIL reset_sel: got %b expected 11", next_PC_sel); end
            checks++; if (i_mem_read !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b expected 0", i_mem_read); end
            checks++; if ({stall_fetch, stall_decode, flush_decode, flush_execute, scan_active} !== 5'b0) begin
                errors++; $display("FAIL reset_ctl: got %b expected 00000", {stall_fetch, stall_decode, flush_decode, flush_execute, scan_active}); end
            checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_cc: got %0d expected 0", cycle_count); end
            tick();
        end
        reset = 1; scan = 0; settle();
        checks++; if (next_PC_sel !== 2'b11 || i_mem_read !== 1'b1) begin
            errors++; $display("FAIL boot: got sel=%b rd=%b expected sel=11 rd=1", next_PC_sel, i_mem_read); end
        checks++; if (target_PC !== RST_PC) begin errors++; $display("FAIL boot_tgt: got %h expected %h", target_PC, RST_PC); end
        tick(); settle();
        checks++; if (next_PC_sel !== 2'b00 || i_mem_read !== 1'b1 || state !== 2'd1) begin
            errors++; $display("FAIL run_idle: got sel=%b rd=%b st=%0d expected sel=00 rd=1 st=1", next_PC_sel, i_mem_read, state); end
    endtask

    task automatic test_exec_redirect();
        int fl = 0;
        clear_inputs(); jalr = 1; exec_target = 20'd8; settle();
        checks++; if (next_PC_sel !== 2'b10 || target_PC !== 20'd8) begin
            errors++; $display("FAIL exec_redirect: got sel=%b tgt=%h expected sel=10 tgt=8", next_PC_sel, target_PC); end
        if (flush_decode && flush_execute) fl++;
        tick(); jalr = 0; exec_target = 20'($urandom);
        for (int i = 0; i < 4; i++) begin
            settle();
            if (flush_decode && flush_execute) fl++;
            checks++; if (flush_decode !== e_fd || next_PC_sel !== e_sel) begin
                errors++; $display("FAIL exec_flush_cyc%0d: got fd=%b sel=%b expected fd=%b sel=%b", i, flush_decode, next_PC_sel, e_fd, e_sel); end
            tick();
        end
        checks++; if (fl !== 2) begin errors++; $display("FAIL exec_flush_len: got %0d expected 2", fl); end
        settle();
        checks++; if (state !== 2'd1 || next_PC_sel !== 2'b00) begin
            errors++; $display("FAIL exec_back_run: got st=%0d sel=%b expected st=1 sel=00", state, next_PC_sel); end
    endtask

    task automatic test_priority();
        clear_inputs(); jal = 1; jal_target = 20'd12; jalr = 1; exec_target = 20'd4; settle();
        checks++; if (target_PC !== 20'd4 || flush_execute !== 1'b1 || next_PC_sel !== 2'b10) begin
            errors++; $display("FAIL priority: got tgt=%h fe=%b sel=%b expected tgt=4 fe=1 sel=10", target_PC, flush_execute, next_PC_sel); end
        tick(); clear_inputs(); tick(); tick();
    endtask

    task automatic test_imem_pending();
        clear_inputs(); imh = 1;
        for (int i = 0; i < 3; i++) begin
            jal = (i == 0); jal_target = 20'd12; settle();
            checks++; if (i_mem_read !== 1'b0 || next_PC_sel !== 2'b01) begin
                errors++; $display("FAIL imem_hold%0d: got rd=%b sel=%b expected rd=0 sel=01", i, i_mem_read, next_PC_sel); end
            tick();
        end
        clear_inputs(); settle();
        checks++; if (next_PC_sel !== 2'b10 || target_PC !== 20'd12 || flush_decode !== 1'b1 || flush_execute !== 1'b0) begin
            errors++; $display("FAIL imem_issue: got sel=%b tgt=%h fd=%b fe=%b expected sel=10 tgt=c fd=1 fe=0",
                next_PC_sel, target_PC, flush_decode, flush_execute); end
        tick(); settle();
        checks++; if (next_PC_sel !== 2'b00) begin errors++; $display("FAIL imem_after: got %b expected 00", next_PC_sel); end
        imh = 1; jal = 1; jal_target = 20'd12; tick();
        jal = 0; jalr = 1; exec_target = 20'd20; tick();
        jalr = 0; tick();
        imh = 0; settle();
        checks++; if (target_PC !== 20'd20 || flush_execute !== 1'b1 || next_PC_sel !== 2'b10) begin
            errors++; $display("FAIL imem_overwrite: got tgt=%h fe=%b sel=%b expected tgt=14 fe=1 sel=10", target_PC, flush_execute, next_PC_sel); end
        tick(); tick(); tick();
    endtask

    task automatic test_data_stall();
        clear_inputs(); tdh = 1;
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++; if ({stall_fetch, stall_decode, flush_execute} !== 3'b111 || next_PC_sel !== 2'b01) begin
                errors++; $display("FAIL data_stall%0d: got sf/sd/fe=%b sel=%b expected 111 sel=01",
                    i, {stall_fetch, stall_decode, flush_execute}, next_PC_sel); end
            tick();
        end
        tdh = 0; settle();
        checks++; if (stall_fetch !== 1'b0 || next_PC_sel !== 2'b00 || state !== e_state) begin
            errors++; $display("FAIL data_release: got sf=%b sel=%b st=%0d expected sf=0 sel=00 st=%0d", stall_fetch, next_PC_sel, state, e_state); end
        tick();
    endtask

    task automatic test_flush_reload();
        int fl = 0;
        clear_inputs(); jalr = 1; exec_target = 20'd8; settle();
        if (flush_decode) fl++;
        tick(); exec_target = 20'd16; jal = 1; jal_target = 20'd12; settle();
        checks++; if (target_PC !== 20'd16 || next_PC_sel !== 2'b10) begin
            errors++; $display("FAIL reload_tgt: got tgt=%h sel=%b expected tgt=10 sel=10", target_PC, next_PC_sel); end
        if (flush_decode) fl++;
        tick(); clear_inputs();
        for (int i = 0; i < 3; i++) begin settle(); if (flush_decode) fl++; tick(); end
        checks++; if (fl !== 3) begin errors++; $display("FAIL reload_len: got %0d expected 3", fl); end
    endtask

    task automatic test_scan();
        int highs = 0;
        clear_inputs(); reset = 0; tick(); tick();
        reset = 1; scan = 1;
        for (int i = 0; i < 10; i++) begin
            settle();
            if (scan_active) highs++;
            checks++; if (scan_active !== e_scan || cycle_count !== e_cc) begin
                errors++; $display("FAIL scan_cyc%0d: got sa=%b cc=%0d expected sa=%b cc=%0d", i, scan_active, cycle_count, e_scan, e_cc); end
            tick();
        end
        checks++; if (highs !== 3) begin errors++; $display("FAIL scan_window: got %0d expected 3", highs); end
        scan = 0;
    endtask

    task automatic test_reset_mid();
        clear_inputs(); jalr = 1; exec_target = 20'd24; tick();
        jalr = 0; reset = 0; tick();
        reset = 1; settle();
        checks++; if (state !== 2'd0 || next_PC_sel !== 2'b11) begin
            errors++; $display("FAIL midflush_boot: got st=%0d sel=%b expected st=0 sel=11", state, next_PC_sel); end
        tick(); settle();
        checks++; if (flush_decode !== 1'b0 || state !== 2'd1 || next_PC_sel !== 2'b00) begin
            errors++; $display("FAIL midflush_run: got fd=%b st=%0d sel=%b expected fd=0 st=1 sel=00", flush_decode, state, next_PC_sel); end
        imh = 1; jal = 1; jal_target = 20'd12; tick();
        imh = 0; jal = 0; reset = 0; tick();
        reset = 1; tick(); settle();
        checks++; if (next_PC_sel !== 2'b00 || target_PC !== RST_PC) begin
            errors++; $display("FAIL pend_discard: got sel=%b tgt=%h expected sel=00 tgt=%h", next_PC_sel, target_PC, RST_PC); end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(59) != 0);
            jalr = ($urandom_range(7) == 0); jal = ($urandom_range(7) == 0);
            tdh = ($urandom_range(7) == 0); dmi = ($urandom_range(15) == 0);
            dmr = ($urandom_range(15) == 0); imh = ($urandom_range(5) == 0);
            scan = $urandom_range(1);
            exec_target = 20'($urandom); jal_target = 20'($urandom);
            settle();
            checks++; if (next_PC_sel !== e_sel) begin errors++; $display("FAIL rnd%0d_sel: got %b expected %b", i, next_PC_sel, e_sel); end
            checks++; if (target_PC !== e_tgt) begin errors++; $display("FAIL rnd%0d_tgt: got %h expected %h", i, target_PC, e_tgt); end
            checks++; if ({i_mem_read, stall_fetch, stall_decode, flush_decode, flush_execute} !== {e_rd, e_sf, e_sd, e_fd, e_fe}) begin
                errors++; $display("FAIL rnd%0d_ctl: got %b expected %b", i,
                    {i_mem_read, stall_fetch, stall_decode, flush_decode, flush_execute}, {e_rd, e_sf, e_sd, e_fd, e_fe}); end
            checks++; if (state !== e_state) begin errors++; $display("FAIL rnd%0d_state: got %0d expected %0d", i, state, e_state); end
            checks++; if (cycle_count !== e_cc || scan_active !== e_scan) begin
                errors++; $display("FAIL rnd%0d_cnt: got cc=%0d sa=%b expected cc=%0d sa=%b", i, cycle_count, scan_active, e_cc, e_scan); end
            tick();
        end
    endtask

    initial begin
        clear_inputs();
        reset = 0;
        test_reset();
        test_exec_redirect();
        test_priority();
        test_imem_pending();
        test_data_stall();
        test_flush_reload();
        test_scan();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_redirect_control.md
PIPELINE_REDIRECT_CONTROL -- requirements
Module: pipeline_redirect_control

Interface
REQ-001 SHALL have parameter ADDRESS_BITS, 20, PC width.
REQ-002 SHALL have parameter RESET_PC, 0, boot fetch address.
REQ-003 SHALL have parameter FLUSH_CYCLES, 2, bubbles inserted after a redirect (range 1-7).
REQ-004 SHALL have parameter SCAN_CYCLES_MIN / SCAN_CYCLES_MAX, 0 / 1000, cycle window during which scan_active may assert.
REQ-005 Ports SHALL be:
- clock  in  1  sole clock, rising edge
- reset  in  1  reset, synchronous, active-low
- JALR_branch_hazard  in  1  execute-stage redirect (taken branch or JALR)
- exec_target  in  ADDRESS_BITS  execute redirect address
- JAL_hazard  in  1  decode-stage JAL redirect
- JAL_target_decode  in  ADDRESS_BITS  JAL address
- true_data_hazard, d_mem_issue_hazard, d_mem_recv_hazard, i_mem_hazard  in  1 each  stall causes
- next_PC_sel  out  2  00 PC+4, 01 hold, 10 target_PC, 11 RESET_PC
- target_PC  out  ADDRESS_BITS  redirect address
- i_mem_read  out  1  fetch request
- stall_fetch, stall_decode  out  1 each  hold stage registers
- flush_decode, flush_execute  out  1 each  insert bubble
- state  out  2  FSM state for debug
- cycle_count  out  32  cycles since reset release
- scan  in  1  debug enable; scan_active  out  1  scan AND cycle_count inside [MIN,MAX]

Function
REQ-006 FSM states SHALL be BOOT(0), RUN(1), STALL(2), FLUSH(3).
REQ-007 BOOT SHALL last exactly one cycle after reset release: next_PC_sel=11, i_mem_read=1, then RUN.
REQ-008 RUN with no hazard SHALL drive next_PC_sel=00, i_mem_read=1, all stall/flush 0.
REQ-009 Stall cause = true_data_hazard|d_mem_issue_hazard|d_mem_recv_hazard|i_mem_hazard; in RUN, stall cause with no redirect SHALL enter STALL the same cycle combinationally: next_PC_sel=01, stall_fetch=1, stall_decode=1, flush_execute=true_data_hazard.
REQ-010 Redirect priority SHALL be JALR_branch_hazard over JAL_hazard; target_PC=exec_target or JAL_target_decode respectively, next_PC_sel=10 in the detection cycle.
REQ-011 Execute redirect SHALL assert flush_decode and flush_execute for FLUSH_CYCLES cycles starting at detection; JAL redirect SHALL assert flush_decode only, for 1 cycle.
REQ-012 A flush counter (3 bits) SHALL load FLUSH_CYCLES-1 on entering FLUSH, decrement per cycle, return to RUN at 0.
REQ-013 Execute redirect arriving during FLUSH SHALL reload the counter and update target_PC; JAL_hazard during FLUSH SHALL be ignored.
REQ-014 Redirect arriving while i_mem_hazard=1 SHALL be latched (pending flag + address); next_PC_sel=10 with the latched target SHALL be issued in the first cycle i_mem_hazard=0; a later execute redirect overwrites the pending one.
REQ-015 i_mem_read SHALL be 0 whenever i_mem_hazard=1 or state=FLUSH with counter>0.
REQ-016 Simultaneous stall cause and execute redirect: redirect SHALL win (flush, not stall); pending logic of REQ-014 still applies for i_mem_hazard.
REQ-017 cycle_count SHALL increment every cycle after reset release and saturate at all-ones.

Reset
REQ-018 reset=0 at a rising edge SHALL force state=BOOT, counters=0, pending=0, target register=RESET_PC.
REQ-019 While reset=0 outputs SHALL be: next_PC_sel=11, i_mem_read=0, all stall/flush=0, scan_active=0, cycle_count=0.
REQ-020 Reset mid-FLUSH or mid-STALL SHALL discard pending redirect and flush count.

Structure
REQ-021 State encodings and next_PC_sel codes SHALL live in a shared core control package used by control_unit.
REQ-022 Flush counter with load/decrement/zero SHALL be one sub-module, redirect_flush_counter.

Verification
REQ-023 reset low 5 cycles, release -> 1 cycle next_PC_sel=11 i_mem_read=1, then RUN next_PC_sel=00.
REQ-024 JALR_branch_hazard=1, exec_target=8, FLUSH_CYCLES=2 -> next_PC_sel=10, target_PC=8, flush_decode/flush_execute high exactly 2 cycles, then RUN.
REQ-025 JAL_hazard=1 with JAL_target_decode=12 and JALR_branch_hazard=1 exec_target=4 same cycle -> target_PC=4, JAL ignored.
REQ-026 i_mem_hazard=1 for 3 cycles with JAL_hazard pulse (target 12) in cycle 1 -> i_mem_read=0, next_PC_sel=01 for 3 cycles, then next_PC_sel=10 target_PC=12.
REQ-027 true_data_hazard=1 2 cycles -> stall_fetch=stall_decode=flush_execute=1 two cycles, next_PC_sel=01.
REQ-028 scan=1, SCAN_CYCLES_MIN=3, MAX=5 -> scan_active high only at cycle_count 3,4,5.
